// File: rtl/hop_pkg.sv
// ============================================================================
// Module   : hop_pkg
// Purpose  : Shared hop-scheduler constants and state encoding for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package hop_pkg;

  localparam int HOP_TX_BITS_WIDTH = 128;
  localparam int HOP_NTX_BITS      = $clog2(HOP_TX_BITS_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_DWELL     = 2'd3
  } hop_state_e;

endpackage

`default_nettype wire

// File: rtl/hop_sched_if.sv
// ============================================================================
// Module   : hop_sched_if
// Purpose  : Scheduler-to-scan-loader link (data_in / srst / scan_load_chip).
// Revision : 1.0
// ============================================================================
`default_nettype none

interface hop_sched_if
  import hop_pkg::*;
#(
  parameter int TX_BITS_WIDTH = HOP_TX_BITS_WIDTH
) ();

  logic [TX_BITS_WIDTH-1:0] scan_data;
  logic                     scan_srst;
  logic                     scan_done;

  modport master (output scan_data, output scan_srst, input  scan_done);
  modport slave  (input  scan_data, input  scan_srst, output scan_done);

endinterface

`default_nettype wire

// File: rtl/hop_table.sv
// ============================================================================
// Module   : hop_table
// Purpose  : Hop word register array, one write port, one combinational read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hop_table #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  wire logic             clk,
  input  wire logic             wr_en_i,
  input  wire logic [AW-1:0]    wr_addr_i,
  input  wire logic [WIDTH-1:0] wr_data_i,
  input  wire logic [AW-1:0]    rd_addr_i,
  output logic      [WIDTH-1:0] rd_data_o
);

  // Deliberately unreset: table contents survive a scheduler reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

`default_nettype wire

// File: rtl/hop_sched.sv
// ============================================================================
// Module   : hop_sched
// Purpose  : Steps through a hop table, issuing one scan load per hop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hop_sched
  import hop_pkg::*;
#(
  parameter int TX_BITS_WIDTH = HOP_TX_BITS_WIDTH,
  parameter int NUM_HOPS      = 8,
  parameter int IDX_WIDTH     = 3,
  parameter int DWELL_WIDTH   = 32,
  parameter int TIMEOUT       = 1024
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     enable,
  input  wire logic [IDX_WIDTH:0]       num_hops,
  input  wire logic [DWELL_WIDTH-1:0]   dwell_cycles,
  input  wire logic                     wr_en,
  input  wire logic [IDX_WIDTH-1:0]     wr_addr,
  input  wire logic [TX_BITS_WIDTH-1:0] wr_data,
  hop_sched_if.master                   scan,
  output logic                          busy,
  output logic [IDX_WIDTH-1:0]          hop_idx,
  output logic [15:0]                   hop_cnt,
  output logic                          err_timeout
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // Compared before the increment, so the last WAIT_DONE cycle is TIMEOUT-2.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

  hop_state_e               state_q;
  logic                     busy_q;
  logic [TX_BITS_WIDTH-1:0] scan_data_q;
  logic                     scan_srst_q;
  logic [IDX_WIDTH-1:0]     hop_idx_q;
  logic [15:0]              hop_cnt_q;
  logic                     err_q;
  logic [TMO_W-1:0]         tmo_q;
  logic [DWELL_WIDTH-1:0]   dwell_q;

  logic [IDX_WIDTH-1:0]     idle_idx_d;
  logic [IDX_WIDTH:0]       idx_inc_d;
  logic [IDX_WIDTH-1:0]     next_idx_d;
  logic [IDX_WIDTH-1:0]     rd_addr_d;
  logic [TX_BITS_WIDTH-1:0] rd_data_d;
  logic [DWELL_WIDTH-1:0]   dwell_load_d;
  logic                     hops_active_d;

  always_comb begin
    hops_active_d = (num_hops != '0);
    idle_idx_d    = ({1'b0, hop_idx_q} >= num_hops) ? '0 : hop_idx_q;
    idx_inc_d     = {1'b0, hop_idx_q} + (IDX_WIDTH+1)'(1);
    next_idx_d    = (idx_inc_d >= num_hops) ? '0 : idx_inc_d[IDX_WIDTH-1:0];
    rd_addr_d     = (state_q == ST_DWELL) ? next_idx_d : idle_idx_d;
    dwell_load_d  = (dwell_cycles == '0) ? '0 : dwell_cycles - DWELL_WIDTH'(1);
  end

  hop_table #(
    .WIDTH (TX_BITS_WIDTH),
    .DEPTH (NUM_HOPS),
    .AW    (IDX_WIDTH)
  ) u_table (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr_d),
    .rd_data_o (rd_data_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      scan_data_q <= '0;
      scan_srst_q <= 1'b0;
      hop_idx_q   <= '0;
      hop_cnt_q   <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
      dwell_q     <= '0;
    end else begin
      scan_srst_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (enable && hops_active_d && !err_q) begin
            hop_idx_q   <= idle_idx_d;
            scan_data_q <= rd_data_d;
            scan_srst_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tmo_q   <= '0;
          state_q <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          tmo_q <= tmo_q + TMO_W'(1);
          if (scan.scan_done) begin
            hop_cnt_q <= hop_cnt_q + 16'd1;
            dwell_q   <= dwell_load_d;
            state_q   <= ST_DWELL;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_DWELL: begin
          if (dwell_q == '0) begin
            hop_idx_q <= next_idx_d;
            if (enable && hops_active_d) begin
              scan_data_q <= rd_data_d;
              scan_srst_q <= 1'b1;
              state_q     <= ST_LOAD;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            dwell_q <= dwell_q - DWELL_WIDTH'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign scan.scan_data = scan_data_q;
  assign scan.scan_srst = scan_srst_q;
  assign busy           = busy_q;
  assign hop_idx        = hop_idx_q;
  assign hop_cnt        = hop_cnt_q;
  assign err_timeout    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hop_sched.sv
// ============================================================================
// Module   : tb_hop_sched
// Purpose  : Scoreboard bench for hop_sched with a scan-loader response stub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hop_sched;

  localparam int W  = 128;
  localparam int IW = 3;

  typedef struct {
    logic [IW-1:0] idx;
    logic [W-1:0]  data;
    int            gap;   // required srst-to-srst spacing, 0 = not checked
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [IW:0]   num_hops = '0;
  logic [31:0]   dwell_cycles = '0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          busy;
  logic [IW-1:0] hop_idx;
  logic [15:0]   hop_cnt;
  logic          err_timeout;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_srst_cyc = 0;
  int   stub_delay = 0;
  int   stub_cnt = 0;
  exp_t sb_q[$];

  hop_sched_if #(.TX_BITS_WIDTH(W)) scan_bus ();

  hop_sched #(
    .TX_BITS_WIDTH (W),
    .NUM_HOPS      (8),
    .IDX_WIDTH     (IW),
    .DWELL_WIDTH   (32),
    .TIMEOUT       (1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .num_hops     (num_hops),
    .dwell_cycles (dwell_cycles),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .scan         (scan_bus.master),
    .busy         (busy),
    .hop_idx      (hop_idx),
    .hop_cnt      (hop_cnt),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] word(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Loader stub: one-cycle scan_done stub_delay cycles after each srst.
  initial begin
    scan_bus.scan_done = 1'b0;
    forever begin
      @(negedge clk);
      scan_bus.scan_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) scan_bus.scan_done = 1'b1;
      end
      if (scan_bus.scan_srst && stub_delay > 0) stub_cnt = stub_delay;
    end
  end

  // Monitor: every load pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!reset && scan_bus.scan_srst) begin
      if (sb_q.size() == 0) begin
        check("unexpected_srst", W'(scan_bus.scan_srst), W'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("scan_data", scan_bus.scan_data, e.data);
        check("hop_idx_at_load", W'(hop_idx), W'(e.idx));
        if (e.gap != 0) check("srst_spacing", W'(cyc - last_srst_cyc), W'(e.gap));
      end
      last_srst_cyc = cyc;
    end
  end

  task automatic push(input int idx, input logic [7:0] b, input int gap);
    exp_t e;
    e.idx  = IW'(idx);
    e.data = word(b);
    e.gap  = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (hop_cnt != 16'(target) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (hop_cnt != 16'(target)) check("wait_hop_cnt_timeout", W'(hop_cnt), W'(target));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reached_idle", W'(busy), W'(0));
  endtask

  task automatic wait_srst();
    int n;
    n = 0;
    while (!scan_bus.scan_srst && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!scan_bus.scan_srst) check("wait_srst_timeout", W'(0), W'(1));
  endtask

  task automatic write_entry(input int a, input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = IW'(a); wr_data = word(b);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    int t_err;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_scan_data", scan_bus.scan_data, '0);
    check("rst_srst_busy", W'({scan_bus.scan_srst, busy}), W'(0));
    check("rst_idx_cnt_err", W'({hop_idx, hop_cnt, err_timeout}), W'(0));

    // Three-entry loop
    write_entry(0, 8'hA1); write_entry(1, 8'hB2);
    write_entry(2, 8'hC3); write_entry(3, 8'hD4);
    num_hops = 4'd3; dwell_cycles = 32'd5; stub_delay = 10;
    push(0, 8'hA1, 0); push(1, 8'hB2, 16); push(2, 8'hC3, 16); push(0, 8'hA1, 16);
    enable = 1'b1;
    wait_cnt(4);
    enable = 1'b0;
    check("loop_hop_cnt", W'(hop_cnt), W'(4));
    wait_idle();
    check("loop_idx_after", W'(hop_idx), W'(1));

    // Disable during WAIT_DONE, then re-enable
    push(1, 8'hB2, 0);
    @(negedge clk); enable = 1'b1;
    wait_srst();
    repeat (2) @(negedge clk);
    enable = 1'b0;
    wait_idle();
    check("disable_hop_cnt", W'(hop_cnt), W'(5));
    check("disable_idx_adv", W'(hop_idx), W'(2));
    push(2, 8'hC3, 0);
    enable = 1'b1;
    wait_cnt(6);
    enable = 1'b0;
    wait_idle();
    check("reenable_idx_wrap", W'(hop_idx), W'(0));

    // dwell_cycles = 0 behaves as 1
    dwell_cycles = 32'd0; stub_delay = 3;
    push(0, 8'hA1, 0); push(1, 8'hB2, 5);
    enable = 1'b1;
    wait_cnt(8);
    enable = 1'b0;
    wait_idle();
    check("dwell0_idx", W'(hop_idx), W'(2));

    // num_hops = 0 never loads
    num_hops = 4'd0;
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("nohops_busy", W'(busy), W'(0));
    enable = 1'b0;

    // Shrink num_hops 4 -> 2 while on index 3
    num_hops = 4'd4; dwell_cycles = 32'd5; stub_delay = 10;
    push(2, 8'hC3, 0); push(3, 8'hD4, 16);
    @(negedge clk); enable = 1'b1;
    wait_cnt(10);
    check("shrink_idx3", W'(hop_idx), W'(3));
    num_hops = 4'd2;
    push(0, 8'hA1, 16);
    wait_cnt(11);
    enable = 1'b0;
    wait_idle();
    check("shrink_idx_after", W'(hop_idx), W'(1));

    // Write to entry 1 in its own capture cycle
    push(1, 8'hB2, 0); push(0, 8'hA1, 16); push(1, 8'hEE, 16);
    @(negedge clk);
    enable = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = word(8'hEE);
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    check("collision_holds_old", scan_bus.scan_data, word(8'hB2));
    wait_cnt(14);
    enable = 1'b0;
    wait_idle();
    check("collision_idx", W'(hop_idx), W'(0));

    // Reset while in DWELL
    push(0, 8'hA1, 0);
    enable = 1'b1;
    wait_cnt(15);
    reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check("midrst_scan_data", scan_bus.scan_data, '0);
    check("midrst_srst_busy", W'({scan_bus.scan_srst, busy}), W'(0));
    check("midrst_idx_cnt_err", W'({hop_idx, hop_cnt, err_timeout}), W'(0));
    reset = 1'b0;
    push(0, 8'hA1, 0); push(1, 8'hEE, 16);
    @(negedge clk); enable = 1'b1;
    wait_cnt(2);
    enable = 1'b0;
    wait_idle();

    // Missing scan_done
    stub_delay = 0;
    push(0, 8'hA1, 0);
    enable = 1'b1;
    for (int i = 0; i < 1200 && !err_timeout; i++) @(negedge clk);
    t_err = cyc;
    check("timeout_err", W'(err_timeout), W'(1));
    check("timeout_latency", W'(t_err - last_srst_cyc), W'(1024));
    check("timeout_busy", W'(busy), W'(0));
    repeat (50) @(negedge clk);
    check("timeout_sticky", W'({err_timeout, busy}), W'(2'b10));
    check("timeout_hop_cnt", W'(hop_cnt), W'(2));
    enable = 1'b0;
    check("sb_drained", W'(sb_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hop_sched.md
# hop_sched

Hop scheduler for the anchor's scan-chain hop controller. It holds a small table of hop configuration words and steps through them in a loop. For each hop it presents the word on `scan_data`, pulses `scan_srst`, waits for the chip-load pulse, then waits a programmable number of cycles before the next hop. It sits between host/register logic and the scan-chain loader's `srst`/`data_in`/`scan_load_chip` interface.

## Interface
- `TX_BITS_WIDTH`, default 128: width of one hop word; matches the loader's `data_in`.
- `NUM_HOPS`, default 8: table depth.
- `IDX_WIDTH`, default 3: index width, equal to clog2(`NUM_HOPS`).
- `DWELL_WIDTH`, default 32: dwell counter width.
- `TIMEOUT`, default 1024: maximum number of cycles to wait for `scan_done` after `scan_srst`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  level; run the hop loop while high.
- `num_hops`  in  `IDX_WIDTH`+1  active entries, valid range 0..`NUM_HOPS`; sampled in IDLE and DWELL.
- `dwell_cycles`  in  `DWELL_WIDTH`  cycles between `scan_done` and the next load; 0 is treated as 1.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  `IDX_WIDTH`  table write address.
- `wr_data`  in  `TX_BITS_WIDTH`  table write data.
- `scan_data`  out  `TX_BITS_WIDTH`  registered hop word; drives the loader's `data_in`.
- `scan_srst`  out  1  one-cycle load-start pulse; drives the loader's `srst`.
- `scan_done`  in  1  chip-load pulse from the loader (`scan_load_chip`).
- `busy`  out  1  high in any state other than IDLE.
- `hop_idx`  out  `IDX_WIDTH`  index of the word currently on `scan_data`.
- `hop_cnt`  out  16  number of completed hops; wraps at 16 bits.
- `err_timeout`  out  1  sticky; set on a missing `scan_done`.

## Operation
- Table: `NUM_HOPS`×`TX_BITS_WIDTH` register array. Writes are accepted in every state.
- Reset behaviour:
  - The table is not cleared.
  - Outputs: `scan_data`=0, `scan_srst`=0, `busy`=0, `hop_idx`=0, `hop_cnt`=0, `err_timeout`=0, state IDLE.
- FSM states: IDLE, LOAD, WAIT_DONE, DWELL.
- IDLE:
  - If `enable`=1, `num_hops`≠0 and `err_timeout`=0, go to LOAD.
  - On that transition, `scan_data` ← table[`hop_idx`].
  - If `hop_idx` ≥ `num_hops`, force `hop_idx` to 0 before the read.
- LOAD: `scan_srst`=1 for exactly this one cycle, then go to WAIT_DONE. The timeout counter clears to 0.
- WAIT_DONE:
  - The timeout counter increments every cycle.
  - If `scan_done`=1: `hop_cnt`++, load the dwell counter with max(`dwell_cycles`,1)−1, go to DWELL.
  - If the counter reaches `TIMEOUT`−1 with no `scan_done`: set `err_timeout`, go to IDLE.
  - `err_timeout` blocks restart until the next `reset`.
- DWELL: the counter decrements each cycle. At 0:
  - `hop_idx` ← (`hop_idx`+1 ≥ `num_hops`) ? 0 : `hop_idx`+1.
  - If `enable`=1 and `num_hops`≠0: capture the new word and go to LOAD.
  - Otherwise go to IDLE, keeping the advanced `hop_idx`.
- `enable` dropping in LOAD or WAIT_DONE does not abort. The current hop completes, and the FSM leaves at the end of DWELL.
- `scan_done` outside WAIT_DONE is ignored.
- If a write hits the entry being captured in the same cycle, the old contents are captured (read-before-write). Writes made after capture do not change `scan_data` until the next capture.

## Timing
- Latency from `enable` to the load pulse: `enable` sampled high in IDLE at cycle N gives `scan_data` valid and `scan_srst`=1 at N+1.
- Hop period is `scan_srst` to `scan_srst` = 1 + (cycles from LOAD to `scan_done`) + max(`dwell_cycles`,1).
- `scan_done` sampled at cycle M gives DWELL at M+1. With `dwell_cycles`=1 the next LOAD is at M+2.
- `scan_data` is stable from LOAD until the next capture. Loader data is therefore held for the whole scan.
- `hop_cnt` and `err_timeout` update on the cycle after the sampling edge.

## Structure
- Shared package `hop_pkg`: state encoding (IDLE=0, LOAD=1, WAIT_DONE=2, DWELL=3) and the default `TX_BITS_WIDTH`/`NTX_BITS` constants, shared with the loader.
- Sub-module `hop_table`: the register array, one write port and one combinational read port. All other logic is inline in `hop_sched`.

## Test plan
- **Three-entry loop.** Write entries 0..2 = 0x…A1, 0x…B2, 0x…C3; set `num_hops`=3, `dwell_cycles`=5; stub responds with `scan_done` 10 cycles after `srst`.
  - Required: `scan_data` sequence A1,B2,C3,A1; `srst` spacing 16 cycles; `hop_cnt`=4 after the 4th done.
- **Timeout.** Stub never asserts `scan_done`, `TIMEOUT`=1024.
  - Required: `err_timeout`=1 exactly 1024 cycles after LOAD; `busy`=0; no further `srst` while `enable` stays 1.
- **Disable mid-hop.** Drop `enable` in WAIT_DONE.
  - Required: done is accepted, DWELL runs, then IDLE with `hop_idx` advanced by 1; re-enable loads that index.
- **Zero-value edges.** `dwell_cycles`=0 behaves as 1. `num_hops`=0 gives no `srst` ever. Shrinking `num_hops` 4→2 while `hop_idx`=3 wraps to index 0.
- **Write/capture collision.** Write entry 1 = 0x…EE in the capture cycle of entry 1.
  - Required: old value on `scan_data`; 0x…EE on the next pass.
- **Reset mid-operation.** Assert `reset` in DWELL.
  - Required: all outputs take their reset values next cycle; table contents are retained.
